// File: rtl/parity_tx_scheduler.sv
// parity_tx_scheduler: round-robin scheduler sharing one 7-bit serial parity
// transmitter among NUM_REQ requesters. Each frame is one LOAD cycle followed
// by 8 SHIFT cycles (7 data bits, then even parity).
// Optional feature: define PARITY_SCHED_GAP_EN to insert one idle GAP cycle
// after every frame. Arbitration then happens in GAP instead of the last SHIFT cycle.
module parity_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [NUM_REQ-1:0]   Req,
  input  logic [7*NUM_REQ-1:0] ReqData,
  output logic [NUM_REQ-1:0]   Ack,
  output logic                 Load,
  output logic [6:0]           LoadData,
  output logic [ID_W-1:0]      GrantId,
  output logic                 BitValid,
  output logic                 FrameDone,
  output logic                 Busy
);

`ifdef PARITY_SCHED_GAP_EN
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
`endif

  state_t              state_reg, state_next;
  logic [2:0]          bit_cnt_reg, bit_cnt_next;
  logic [ID_W-1:0]     grant_reg, grant_next;
  logic [ID_W-1:0]     last_reg, last_next;
  logic [6:0]          data_reg, data_next;
  logic [NUM_REQ-1:0]  ack_reg, ack_next;
  logic                load_reg, bit_valid_reg, frame_done_reg, busy_reg;
  logic                load_next, bit_valid_next, frame_done_next, busy_next;

  logic                win;
  logic [ID_W-1:0]     win_id;
  logic                arb_en;
  logic [6:0]          req_data_arr [NUM_REQ];

  // Unpack the flat request data bus into one 7-bit slice per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_data_arr[gi] = ReqData[7*gi +: 7];
  end

  // Rotating-priority search starting just after the last granted requester.
  always_comb begin
    int              cand;
    logic [ID_W-1:0] idx;
    win    = 1'b0;
    win_id = '0;
    cand   = 0;
    idx    = '0;
    // Walk from farthest to nearest so the nearest asserted request wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last_reg) + k) % NUM_REQ;
      idx  = ID_W'(cand);
      if (Req[idx]) begin
        win    = 1'b1;
        win_id = idx;
      end
    end
  end

  // Next-state, grant capture and next values of the registered outputs.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    grant_next   = grant_reg;
    last_next    = last_reg;
    data_next    = data_reg;
    arb_en       = 1'b0;
    case (state_reg)
      IDLE:  arb_en = 1'b1;
      LOAD: begin
        state_next   = SHIFT;
        bit_cnt_next = 3'd0;
      end
      SHIFT: begin
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
`ifdef PARITY_SCHED_GAP_EN
          state_next = GAP;
`else
          arb_en = 1'b1;
`endif
        end
      end
`ifdef PARITY_SCHED_GAP_EN
      GAP:   arb_en = 1'b1;
`endif
      default: state_next = IDLE;
    endcase
    if (arb_en) begin
      if (win) begin
        state_next = LOAD;
        grant_next = win_id;
        last_next  = win_id;
        data_next  = req_data_arr[win_id];
      end else begin
        state_next = IDLE;
      end
    end
    load_next       = (state_next == LOAD);
    bit_valid_next  = (state_next == SHIFT);
    frame_done_next = (state_next == SHIFT) && (bit_cnt_next == 3'd7);
    busy_next       = (state_next != IDLE);
  end

  // One-hot acknowledge for the requester whose data is being loaded.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
    assign ack_next[gi] = load_next && (grant_next == ID_W'(gi));
  end

  // State and registered outputs; asynchronous reset clears everything.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= 3'd0;
      grant_reg      <= '0;
      last_reg       <= ID_W'(NUM_REQ - 1);
      data_reg       <= 7'd0;
      ack_reg        <= '0;
      load_reg       <= 1'b0;
      bit_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      grant_reg      <= grant_next;
      last_reg       <= last_next;
      data_reg       <= data_next;
      ack_reg        <= ack_next;
      load_reg       <= load_next;
      bit_valid_reg  <= bit_valid_next;
      frame_done_reg <= frame_done_next;
      busy_reg       <= busy_next;
    end
  end

  assign Ack       = ack_reg;
  assign Load      = load_reg;
  assign LoadData  = data_reg;
  assign GrantId   = grant_reg;
  assign BitValid  = bit_valid_reg;
  assign FrameDone = frame_done_reg;
  assign Busy      = busy_reg;

endmodule

// File: tb/tb_parity_tx_scheduler.sv
// Testbench for parity_tx_scheduler: a directed vector table, hand-written
// multi-cycle sequences, and randomized requests checked against a
// frame-queue reference model. Honours PARITY_SCHED_GAP_EN.
module tb_parity_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef PARITY_SCHED_GAP_EN
  localparam int PERIOD = 10;
  localparam bit GAPB   = 1'b1;
`else
  localparam int PERIOD = 9;
  localparam bit GAPB   = 1'b0;
`endif

  logic                 Clock;
  logic                 Resetn;
  logic [NUM_REQ-1:0]   Req;
  logic [7*NUM_REQ-1:0] ReqData;
  logic [NUM_REQ-1:0]   Ack;
  logic                 Load;
  logic [6:0]           LoadData;
  logic [ID_W-1:0]      GrantId;
  logic                 BitValid;
  logic                 FrameDone;
  logic                 Busy;

  parity_tx_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .Clock(Clock), .Resetn(Resetn), .Req(Req), .ReqData(ReqData),
    .Ack(Ack), .Load(Load), .LoadData(LoadData), .GrantId(GrantId),
    .BitValid(BitValid), .FrameDone(FrameDone), .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of expected cycles ----------------
  typedef struct {
    bit load; int ack; int data; int gid; bit bv; bit fd; bit busy;
  } exp_t;

  exp_t mq[$];
  int   last_m, gid_m, data_m;

  task automatic model_reset();
    mq.delete();
    last_m = NUM_REQ - 1;
    gid_m  = 0;
    data_m = 0;
  endtask

  // One frame = load cycle, 8 bit cycles, optional gap cycle.
  task automatic push_frame(input int w, input int d);
    exp_t e;
    e = '{load: 1'b1, ack: (1 << w), data: d, gid: w, bv: 1'b0, fd: 1'b0, busy: 1'b1};
    mq.push_back(e);
    for (int k = 0; k < 8; k++) begin
      e = '{load: 1'b0, ack: 0, data: d, gid: w, bv: 1'b1, fd: (k == 7), busy: 1'b1};
      mq.push_back(e);
    end
    if (GAPB) begin
      e = '{load: 1'b0, ack: 0, data: d, gid: w, bv: 1'b0, fd: 1'b0, busy: 1'b1};
      mq.push_back(e);
    end
  endtask

  // Advance one clock, updating the model from the requests seen at the edge.
  task automatic tick();
    exp_t e;
    int   w;
    if (mq.size() == 0) begin
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int i;
        i = (last_m + k) % NUM_REQ;
        if (w < 0 && Req[i]) w = i;
      end
      if (w >= 0) begin
        last_m = w;
        gid_m  = w;
        data_m = int'(ReqData[7*w +: 7]);
        push_frame(w, data_m);
      end
    end
    @(posedge Clock);
    #1;
    if (mq.size() != 0) e = mq.pop_front();
    else e = '{load: 1'b0, ack: 0, data: data_m, gid: gid_m, bv: 1'b0, fd: 1'b0, busy: 1'b0};
    chk("m_load", int'(Load), int'(e.load));
    chk("m_ack", int'(Ack), e.ack);
    chk("m_gid", int'(GrantId), e.gid);
    chk("m_bitvalid", int'(BitValid), int'(e.bv));
    chk("m_framedone", int'(FrameDone), int'(e.fd));
    chk("m_busy", int'(Busy), int'(e.busy));
    if (e.load) chk("m_loaddata", int'(LoadData), e.data);
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_load", int'(Load), 0);
    chk("rst_ack", int'(Ack), 0);
    chk("rst_gid", int'(GrantId), 0);
    chk("rst_loaddata", int'(LoadData), 0);
    chk("rst_bitvalid", int'(BitValid), 0);
    chk("rst_framedone", int'(FrameDone), 0);
    chk("rst_busy", int'(Busy), 0);
    Resetn = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] req; bit ld; int ack; bit bv; bit fd; bit busy; int gid;
  } vec_t;

  vec_t tbl [11];
  int   exp_bits [8];

  initial begin
    int n, prev, bad;
    int grants [4];
    logic [6:0] cap;
    int bit_v;

    // Req=0010 with data 0x55 for one request, then dropped in the LOAD cycle.
    tbl[0] = '{req: 4'b0010, ld: 1'b1, ack: 2, bv: 1'b0, fd: 1'b0, busy: 1'b1, gid: 1};
    for (int r = 1; r <= 8; r++)
      tbl[r] = '{req: 4'b0000, ld: 1'b0, ack: 0, bv: 1'b1, fd: (r == 8), busy: 1'b1, gid: 1};
    tbl[9]  = '{req: 4'b0000, ld: 1'b0, ack: 0, bv: 1'b0, fd: 1'b0, busy: GAPB, gid: 1};
    tbl[10] = '{req: 4'b0000, ld: 1'b0, ack: 0, bv: 1'b0, fd: 1'b0, busy: 1'b0, gid: 1};
    exp_bits = '{1, 0, 1, 0, 1, 0, 1, 0};

    Req     = '0;
    ReqData = {7'h11, 7'h22, 7'h55, 7'h33};
    model_reset();
    do_reset();

    // Idle after reset with no requests.
    repeat (5) tick();
    $display("[TB] idle after reset checked");

    // Table-driven directed frame.
    cap = '0;
    for (int r = 0; r < 11; r++) begin
      Req = tbl[r].req;
      @(posedge Clock);
      #1;
      chk($sformatf("tbl%0d_load", r), int'(Load), int'(tbl[r].ld));
      chk($sformatf("tbl%0d_ack", r), int'(Ack), tbl[r].ack);
      chk($sformatf("tbl%0d_bitvalid", r), int'(BitValid), int'(tbl[r].bv));
      chk($sformatf("tbl%0d_framedone", r), int'(FrameDone), int'(tbl[r].fd));
      chk($sformatf("tbl%0d_busy", r), int'(Busy), int'(tbl[r].busy));
      chk($sformatf("tbl%0d_gid", r), int'(GrantId), tbl[r].gid);
      if (r == 0) begin
        chk("tbl0_loaddata", int'(LoadData), 'h55);
        cap = LoadData;
      end
      if (r >= 1 && r <= 8) begin
        bit_v = (r - 1 < 7) ? int'(cap[r-1]) : int'(^cap);
        chk($sformatf("tbl%0d_serial", r), bit_v, exp_bits[r-1]);
      end
      $display("[TB] row %0d req=%b load=%b ack=%b bv=%b fd=%b busy=%b gid=%0d",
               r, tbl[r].req, Load, Ack, BitValid, FrameDone, Busy, GrantId);
    end

    // All four requesting continuously from reset: 0,1,2,3,0 at fixed period.
    Req = 4'b1111;
    do_reset();
    n = 0; prev = 0;
    for (int c = 0; c < 80 && n < 5; c++) begin
      tick();
      if (Load) begin
        chk("rr_gid", int'(GrantId), n % 4);
        if (n > 0) chk("rr_period", c - prev, PERIOD);
        $display("[TB] rr grant %0d -> id %0d at cycle %0d", n, GrantId, c);
        prev = c; n++;
      end
    end
    chk("rr_count", n, 5);

    // Requesters 0 and 2 continuously: grants alternate, never 1 or 3.
    Req = 4'b0101;
    do_reset();
    n = 0; bad = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (Ack[1] || Ack[3]) bad++;
      if (Load) begin
        grants[n] = int'(GrantId);
        $display("[TB] alt grant %0d -> id %0d", n, GrantId);
        n++;
      end
    end
    chk("alt_count", n, 4);
    if (n == 4) begin
      chk("alt_g0", grants[0], 0);
      chk("alt_g1", grants[1], 2);
      chk("alt_g2", grants[2], 0);
      chk("alt_g3", grants[3], 2);
    end
    chk("alt_no_ack13", bad, 0);

    // Requester 3 alone, reset pulsed mid-frame at bit count 3.
    Req = 4'b1000;
    do_reset();
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      tick();
      if (Load) n = 1;
    end
    chk("mrst_loaded", n, 1);
    repeat (4) tick();
    #2 Resetn = 1'b0;
    #1;
    chk("mrst_load", int'(Load), 0);
    chk("mrst_ack", int'(Ack), 0);
    chk("mrst_bitvalid", int'(BitValid), 0);
    chk("mrst_framedone", int'(FrameDone), 0);
    chk("mrst_busy", int'(Busy), 0);
    chk("mrst_gid", int'(GrantId), 0);
    #1 Resetn = 1'b1;
    model_reset();
    tick();
    chk("mrst_new_gid", int'(GrantId), 3);
    chk("mrst_new_ack", int'(Ack), 8);
    $display("[TB] mid-frame reset: new grant id %0d ack %b", GrantId, Ack);
    repeat (12) tick();

    // Randomized requesters obeying the hold-until-Ack protocol.
    Req = '0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (Req[i]) begin
          if (Ack[i]) begin
            if ($urandom_range(1, 0) == 0) Req[i] = 1'b0;
            else ReqData[7*i +: 7] = 7'($urandom);
          end
        end else if ($urandom_range(3, 0) == 0) begin
          Req[i] = 1'b1;
          ReqData[7*i +: 7] = 7'($urandom);
        end
      end
      tick();
      if (Load) $display("[TB] rand cycle %0d load id %0d data %h", c, GrantId, LoadData);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
